// File: rtl/counter_bank.sv
// Multi-channel up-counter bank with per-channel runtime-loadable terminal limits.
// Latency: count/done/limit are registered and update one edge after the inputs are sampled; all_done is combinational from done registers.
// Backpressure: none; enable/chan_en gate stepping and a frozen channel simply holds its count.
// Optional feature macro: COUNTER_BANK_IRQ_EN (sticky per-channel interrupt pending bits, OR-reduced onto irq).
module counter_bank #(
  parameter int NUM_CHANNELS  = 4,
  parameter int COUNT_WIDTH   = 8,
  parameter int DEFAULT_LIMIT = 15,
  parameter bit WRAP_MODE     = 1'b0,
  localparam int CHAN_W       = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              enable,
  input  logic [NUM_CHANNELS-1:0]           chan_en,
  input  logic [NUM_CHANNELS-1:0]           restart,
  input  logic                              cfg_wr,
  input  logic [CHAN_W-1:0]                 cfg_sel,
  input  logic [COUNT_WIDTH-1:0]            cfg_limit,
  input  logic [NUM_CHANNELS-1:0]           irq_clear,
  output logic [NUM_CHANNELS*COUNT_WIDTH-1:0] count,
  output logic [NUM_CHANNELS-1:0]           done,
  output logic                              all_done,
  output logic                              irq
);

  localparam logic [COUNT_WIDTH-1:0] RST_LIMIT = COUNT_WIDTH'(DEFAULT_LIMIT);

  logic [COUNT_WIDTH-1:0]  count_q [NUM_CHANNELS];
  logic [COUNT_WIDTH-1:0]  count_d [NUM_CHANNELS];
  logic [COUNT_WIDTH-1:0]  limit_q [NUM_CHANNELS];
  logic [COUNT_WIDTH-1:0]  limit_d [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] done_q;
  logic [NUM_CHANNELS-1:0] done_d;
  // One bit per channel: this edge is a counting step taken while sitting at the limit.
  logic [NUM_CHANNELS-1:0] hit_limit;

  // Per-channel next state; priority is config write, then restart, then counting step.
  always_comb begin
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      count_d[i]   = count_q[i];
      limit_d[i]   = limit_q[i];
      // Wrap mode makes done a single-cycle pulse; one-shot keeps it sticky.
      done_d[i]    = WRAP_MODE ? 1'b0 : done_q[i];
      hit_limit[i] = 1'b0;
      if (cfg_wr && (int'(cfg_sel) == i)) begin
        // Clearing the count here keeps count <= limit when the limit is lowered.
        limit_d[i] = cfg_limit;
        count_d[i] = '0;
        done_d[i]  = 1'b0;
      end else if (restart[i]) begin
        count_d[i] = '0;
        done_d[i]  = 1'b0;
      end else if (enable && chan_en[i] && (WRAP_MODE || !done_q[i])) begin
        if (count_q[i] == limit_q[i]) begin
          hit_limit[i] = 1'b1;
          done_d[i]    = 1'b1;
          if (WRAP_MODE) begin
            count_d[i] = '0;
          end
        end else begin
          count_d[i] = count_q[i] + COUNT_WIDTH'(1);
        end
      end
    end
  end

  // State registers with synchronous reset taking precedence over every other request.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        count_q[i] <= '0;
        limit_q[i] <= RST_LIMIT;
      end
      done_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        count_q[i] <= count_d[i];
        limit_q[i] <= limit_d[i];
      end
      done_q <= done_d;
    end
  end

  // Flatten per-channel counts onto the packed output bus.
  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_count_out
    assign count[g*COUNT_WIDTH +: COUNT_WIDTH] = count_q[g];
  end

  assign done     = done_q;
  assign all_done = &done_q;

`ifdef COUNTER_BANK_IRQ_EN
  logic [NUM_CHANNELS-1:0] irq_pending_q;
  logic [NUM_CHANNELS-1:0] irq_pending_d;

  // Pending bits set on a step at limit; a new set beats a same-cycle clear.
  always_comb begin
    irq_pending_d = hit_limit | (irq_pending_q & ~irq_clear);
  end

  // Pending register; irq is driven straight from flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_pending_q <= '0;
    end else begin
      irq_pending_q <= irq_pending_d;
    end
  end

  assign irq = |irq_pending_q;
`else
  // Interrupts compiled out: ports kept so the interface does not change between builds.
  logic unused_irq_inputs;
  assign unused_irq_inputs = ^{irq_clear, hit_limit};
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_counter_bank.sv
// Bench for counter_bank: one-shot and wrap instances driven by shared stimulus.
// Expected values come from directed constants and a per-channel behavioural model.
// Summary line reports passed/total comparisons.
module tb_counter_bank;
  localparam int N = 4;
  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b0;
  logic         enable = 1'b0;
  logic [N-1:0] chan_en = '0;
  logic [N-1:0] restart = '0;
  logic         cfg_wr = 1'b0;
  logic [1:0]   cfg_sel = '0;
  logic [W-1:0] cfg_limit = '0;
  logic [N-1:0] irq_clear = '0;

  logic [N*W-1:0] cnt0, cnt1;
  logic [N-1:0]   dn0, dn1;
  logic           ad0, ad1, irq0, irq1;

  counter_bank #(.NUM_CHANNELS(N), .COUNT_WIDTH(W), .DEFAULT_LIMIT(15), .WRAP_MODE(1'b0)) u_oneshot (
    .clk(clk), .rst(rst), .enable(enable), .chan_en(chan_en), .restart(restart),
    .cfg_wr(cfg_wr), .cfg_sel(cfg_sel), .cfg_limit(cfg_limit), .irq_clear(irq_clear),
    .count(cnt0), .done(dn0), .all_done(ad0), .irq(irq0));

  counter_bank #(.NUM_CHANNELS(N), .COUNT_WIDTH(W), .DEFAULT_LIMIT(15), .WRAP_MODE(1'b1)) u_wrap (
    .clk(clk), .rst(rst), .enable(enable), .chan_en(chan_en), .restart(restart),
    .cfg_wr(cfg_wr), .cfg_sel(cfg_sel), .cfg_limit(cfg_limit), .irq_clear(irq_clear),
    .count(cnt1), .done(dn1), .all_done(ad1), .irq(irq1));

  int passed = 0;
  int total  = 0;

  // Reference model, index [mode][channel]; mode 0 = one-shot, 1 = wrap.
  int m_cnt  [2][N];
  int m_lim  [2][N];
  bit m_dn   [2][N];
  bit m_pend [2][N];

  function automatic int get_cnt(int m, int i);
    logic [N*W-1:0] bus;
    bus = (m == 0) ? cnt0 : cnt1;
    return int'(bus[i*W +: W]);
  endfunction

  function automatic bit get_dn(int m, int i);
    return (m == 0) ? dn0[i] : dn1[i];
  endfunction

  function automatic bit exp_all_done(int m);
    bit a = 1'b1;
    for (int i = 0; i < N; i++) a &= m_dn[m][i];
    return a;
  endfunction

  function automatic bit exp_irq(int m);
    bit a = 1'b0;
`ifdef COUNTER_BANK_IRQ_EN
    for (int i = 0; i < N; i++) a |= m_pend[m][i];
`endif
    return a;
  endfunction

  // Advance the model by one edge from the current inputs, then clock the DUTs.
  task automatic tick();
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < N; i++) begin
        bit set_irq = 1'b0;
        if (rst) begin
          m_cnt[m][i] = 0; m_lim[m][i] = 15; m_dn[m][i] = 1'b0; m_pend[m][i] = 1'b0;
        end else begin
          if (cfg_wr && int'(cfg_sel) == i) begin
            m_lim[m][i] = int'(cfg_limit); m_cnt[m][i] = 0; m_dn[m][i] = 1'b0;
          end else if (restart[i]) begin
            m_cnt[m][i] = 0; m_dn[m][i] = 1'b0;
          end else if (enable && chan_en[i] && (m == 1 || !m_dn[m][i])) begin
            if (m_cnt[m][i] == m_lim[m][i]) begin
              set_irq = 1'b1;
              m_dn[m][i] = 1'b1;
              if (m == 1) m_cnt[m][i] = 0;
            end else begin
              m_cnt[m][i] = m_cnt[m][i] + 1;
              if (m == 1) m_dn[m][i] = 1'b0;
            end
          end else if (m == 1) begin
            m_dn[m][i] = 1'b0;
          end
          m_pend[m][i] = set_irq | (m_pend[m][i] & !irq_clear[i]);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 0; enable = 0; chan_en = '0; restart = '0; cfg_wr = 0; cfg_sel = '0; cfg_limit = '0; irq_clear = '0;
  endtask

  task automatic do_reset();
    idle_inputs(); rst = 1; tick(); rst = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1; tick(); tick(); rst = 0;
    total++; if (cnt0 !== '0) $display("FAIL reset_cnt_oneshot: got %h want 0", cnt0); else passed++;
    total++; if (cnt1 !== '0) $display("FAIL reset_cnt_wrap: got %h want 0", cnt1); else passed++;
    total++; if (dn0 !== '0 || dn1 !== '0) $display("FAIL reset_done: got %b/%b want 0", dn0, dn1); else passed++;
    total++; if (ad0 !== 1'b0 || ad1 !== 1'b0) $display("FAIL reset_all_done: got %b/%b want 0", ad0, ad1); else passed++;
    total++; if (irq0 !== 1'b0 || irq1 !== 1'b0) $display("FAIL reset_irq: got %b/%b want 0", irq0, irq1); else passed++;
  endtask

  task automatic test_oneshot();
    do_reset();
    enable = 1; chan_en = 4'b0001;
    for (int k = 0; k < 15; k++) tick();
    total++; if (get_cnt(0, 0) !== 15) $display("FAIL oneshot_cnt_edge15: got %0d want 15", get_cnt(0, 0)); else passed++;
    total++; if (dn0[0] !== 1'b0) $display("FAIL oneshot_done_edge15: got %b want 0", dn0[0]); else passed++;
    tick();
    total++; if (dn0 !== 4'b0001) $display("FAIL oneshot_done_edge16: got %b want 0001", dn0); else passed++;
    total++; if (cnt0 !== 32'h0000_000F) $display("FAIL oneshot_cnt_edge16: got %h want 0000000f", cnt0); else passed++;
    total++; if (get_cnt(1, 0) !== 0 || dn1[0] !== 1'b1) $display("FAIL wrap_default_edge16: got cnt %0d done %b want 0/1", get_cnt(1, 0), dn1[0]); else passed++;
    tick();
    total++; if (get_cnt(0, 0) !== 15 || dn0[0] !== 1'b1) $display("FAIL oneshot_hold: got cnt %0d done %b want 15/1", get_cnt(0, 0), dn0[0]); else passed++;
    idle_inputs();
  endtask

  task automatic test_wrap();
    int errs = 0;
    do_reset();
    cfg_wr = 1; cfg_sel = 2; cfg_limit = 3; tick(); cfg_wr = 0;
    enable = 1; chan_en = 4'b0100;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (get_cnt(1, 2) !== (k % 4) || dn1[2] !== (k % 4 == 0)) begin
        $display("FAIL wrap_seq_edge%0d: got cnt %0d done %b want %0d/%0d", k, get_cnt(1, 2), dn1[2], k % 4, (k % 4 == 0));
        errs++;
      end
    end
    total++; if (errs == 0) passed++;
    total++; if (get_cnt(0, 2) !== 3 || dn0[2] !== 1'b1) $display("FAIL oneshot_lim3: got cnt %0d done %b want 3/1", get_cnt(0, 2), dn0[2]); else passed++;
    idle_inputs();
  endtask

  task automatic test_collisions();
    do_reset();
    enable = 1; chan_en = 4'b0010;
    tick(); tick(); tick();
    restart = 4'b0010; cfg_wr = 1; cfg_sel = 1; cfg_limit = 5; tick();
    restart = '0; cfg_wr = 0;
    total++; if (get_cnt(0, 1) !== 0 || get_cnt(1, 1) !== 0) $display("FAIL collide_cnt: got %0d/%0d want 0", get_cnt(0, 1), get_cnt(1, 1)); else passed++;
    for (int k = 0; k < 5; k++) tick();
    total++; if (get_cnt(0, 1) !== 5 || dn0[1] !== 1'b0) $display("FAIL collide_lim5_cnt: got %0d done %b want 5/0", get_cnt(0, 1), dn0[1]); else passed++;
    tick();
    total++; if (get_cnt(0, 1) !== 5 || dn0[1] !== 1'b1) $display("FAIL collide_lim5_done: got %0d done %b want 5/1", get_cnt(0, 1), dn0[1]); else passed++;
    total++; if (get_cnt(1, 1) !== 0 || dn1[1] !== 1'b1) $display("FAIL collide_wrap_lim5: got %0d done %b want 0/1", get_cnt(1, 1), dn1[1]); else passed++;
    rst = 1; cfg_wr = 1; cfg_sel = 0; cfg_limit = 3; tick();
    rst = 0; cfg_wr = 0; chan_en = 4'b0001;
    for (int k = 0; k < 4; k++) tick();
    total++; if (get_cnt(0, 0) !== 4 || dn0[0] !== 1'b0) $display("FAIL rst_beats_cfg: got %0d done %b want 4/0", get_cnt(0, 0), dn0[0]); else passed++;
    idle_inputs();
  endtask

  task automatic test_boundary();
    do_reset();
    cfg_wr = 1; cfg_sel = 3; cfg_limit = 0; tick(); cfg_wr = 0;
    enable = 1; chan_en = 4'b1000; tick();
    total++; if (get_cnt(0, 3) !== 0 || dn0[3] !== 1'b1) $display("FAIL lim0_oneshot: got %0d done %b want 0/1", get_cnt(0, 3), dn0[3]); else passed++;
    tick();
    total++; if (get_cnt(1, 3) !== 0 || dn1[3] !== 1'b1) $display("FAIL lim0_wrap_repeat: got %0d done %b want 0/1", get_cnt(1, 3), dn1[3]); else passed++;
    enable = 0; tick();
    total++; if (dn1[3] !== 1'b0 || dn0[3] !== 1'b1) $display("FAIL lim0_disable: got wrap %b oneshot %b want 0/1", dn1[3], dn0[3]); else passed++;
    do_reset();
    cfg_wr = 1; cfg_sel = 0; cfg_limit = 8'd255; tick(); cfg_wr = 0;
    enable = 1; chan_en = 4'b0001;
    for (int k = 0; k < 255; k++) tick();
    total++; if (get_cnt(0, 0) !== 255 || dn0[0] !== 1'b0) $display("FAIL lim255_edge255: got %0d done %b want 255/0", get_cnt(0, 0), dn0[0]); else passed++;
    tick();
    total++; if (get_cnt(0, 0) !== 255 || dn0[0] !== 1'b1) $display("FAIL lim255_edge256: got %0d done %b want 255/1", get_cnt(0, 0), dn0[0]); else passed++;
    total++; if (get_cnt(1, 0) !== 0 || dn1[0] !== 1'b1) $display("FAIL lim255_wrap: got %0d done %b want 0/1", get_cnt(1, 0), dn1[0]); else passed++;
    tick();
    total++; if (get_cnt(0, 0) !== 255 || get_cnt(1, 0) !== 1 || dn1[0] !== 1'b0) $display("FAIL lim255_after: got %0d/%0d done %b want 255/1/0", get_cnt(0, 0), get_cnt(1, 0), dn1[0]); else passed++;
    idle_inputs();
  endtask

`ifdef COUNTER_BANK_IRQ_EN
  task automatic test_irq();
    do_reset();
    cfg_wr = 1; cfg_sel = 0; cfg_limit = 0; tick(); cfg_wr = 0;
    enable = 1; chan_en = 4'b0001; tick();
    total++; if (irq0 !== 1'b1 || irq1 !== 1'b1) $display("FAIL irq_set: got %b/%b want 1/1", irq0, irq1); else passed++;
    irq_clear = 4'b0001; tick();
    total++; if (irq1 !== 1'b1) $display("FAIL irq_set_beats_clear: got %b want 1", irq1); else passed++;
    total++; if (irq0 !== 1'b0) $display("FAIL irq_clear_oneshot: got %b want 0", irq0); else passed++;
    enable = 0; tick();
    total++; if (irq1 !== 1'b0) $display("FAIL irq_clear_alone: got %b want 0", irq1); else passed++;
    idle_inputs();
  endtask
`endif

  task automatic test_random();
    int errs = 0;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rst       = ($urandom % 80) == 0;
      cfg_wr    = ($urandom % 10) == 0;
      cfg_sel   = 2'($urandom % 4);
      cfg_limit = (($urandom % 4) == 0) ? 8'($urandom % 256) : 8'($urandom % 8);
      enable    = ($urandom % 8) != 0;
      chan_en   = 4'($urandom);
      for (int i = 0; i < N; i++) begin
        restart[i]   = ($urandom % 16) == 0;
        irq_clear[i] = ($urandom % 4) == 0;
      end
      tick();
      for (int m = 0; m < 2; m++) begin
        for (int i = 0; i < N; i++) begin
          total++;
          if (get_cnt(m, i) !== m_cnt[m][i] || get_dn(m, i) !== m_dn[m][i]) begin
            if (errs < 10) $display("FAIL rand_c%0d_m%0d_ch%0d: got cnt %0d done %b want %0d/%b", c, m, i, get_cnt(m, i), get_dn(m, i), m_cnt[m][i], m_dn[m][i]);
            errs++;
          end else passed++;
        end
      end
      total++; if (ad0 !== exp_all_done(0) || ad1 !== exp_all_done(1)) $display("FAIL rand_all_done_c%0d: got %b/%b want %b/%b", c, ad0, ad1, exp_all_done(0), exp_all_done(1)); else passed++;
      total++; if (irq0 !== exp_irq(0) || irq1 !== exp_irq(1)) $display("FAIL rand_irq_c%0d: got %b/%b want %b/%b", c, irq0, irq1, exp_irq(0), exp_irq(1)); else passed++;
    end
    idle_inputs();
  endtask

  initial begin
    #2;
    test_reset();
    test_oneshot();
    test_wrap();
    test_collisions();
    test_boundary();
`ifdef COUNTER_BANK_IRQ_EN
    test_irq();
`endif
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
